// File: rtl/vram_dma_pkg.sv
// dma_pkg: shared FSM encoding, register map, CTRL bits and VRAM base for vram_dma
package dma_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_REM   = 8;
  // Same region the top-level data_addr[31:30] decode routes to VRAM
  localparam logic [31:0] VRAM_BASE = 32'h8000_0000;
endpackage

// File: rtl/vram_dma.sv
// vram_dma: cycle-stealing byte copier from main RAM into VGA VRAM
module vram_dma
  import dma_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_sel,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_wenable,
  output logic [31:0] reg_rdata,
  input  logic        cpu_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wenable,
  input  logic [31:0] mem_rdata,
  output logic        dma_done
);
  state_t           r_state;
  logic [11:0]      r_src;
  logic [6:0]       r_dst;
  logic [LEN_W-1:0] r_len;
  logic [7:0]       r_byte;
  logic             r_done;
  logic             w_wr;
  logic             w_busy;
  logic             w_start;
  logic             w_clear;
  logic             w_abort;
  logic             w_issue;
  logic             w_wr_issue;
  logic             w_last;
  logic [7:0]       w_lane;
  logic             w_unused;
  assign w_wr       = reg_sel & reg_wenable;
  assign w_busy     = r_state != ST_IDLE;
  assign w_start    = w_wr && reg_addr == REG_CTRL && reg_wdata[CTRL_START];
  assign w_clear    = w_wr && reg_addr == REG_CTRL && reg_wdata[CTRL_CLEAR];
  assign w_abort    = w_wr && reg_addr == REG_CTRL && reg_wdata[CTRL_ABORT];
  assign w_issue    = (r_state == ST_READ || r_state == ST_WRITE) && !cpu_busy;
  assign w_wr_issue = w_issue && r_state == ST_WRITE;
  assign w_last     = r_len == LEN_W'(1);
  assign w_unused   = ^reg_wdata[31:12];
  // Byte lane of the fetched word selected by the low source address bits
  always_comb begin
    w_lane = r_src[1] ? (r_src[0] ? mem_rdata[31:24] : mem_rdata[23:16])
                      : (r_src[0] ? mem_rdata[15:8]  : mem_rdata[7:0]);
  end
  // Slave read mux; CTRL packs remaining count above busy/done flags
  always_comb begin
    reg_rdata = reg_addr == REG_SRC ? {20'b0, r_src} :
                reg_addr == REG_DST ? {25'b0, r_dst} :
                reg_addr == REG_LEN ? 32'(r_len) :
                32'({r_len, 6'b0, r_done, w_busy});
  end
  // Master port is fully zeroed whenever the DMA does not own the bus
  always_comb begin
    mem_req     = w_issue;
    mem_addr    = !w_issue ? 32'b0 :
                  w_wr_issue ? (VRAM_BASE | {25'b0, r_dst}) :
                  {20'b0, r_src[11:2], 2'b00};
    mem_wdata   = w_wr_issue ? {24'b0, r_byte} : 32'b0;
    mem_wenable = w_wr_issue ? 4'b0001 : 4'b0000;
  end
  assign dma_done = r_done;
  // Register file and transfer FSM; abort overrides the next state last
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_byte  <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_wr && !w_busy && reg_addr == REG_SRC) r_src <= reg_wdata[11:0];
      if (w_wr && !w_busy && reg_addr == REG_DST) r_dst <= reg_wdata[6:0];
      if (w_wr && !w_busy && reg_addr == REG_LEN) r_len <= reg_wdata[LEN_W-1:0];
      if (w_clear) r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start && !w_abort) begin
            r_done  <= r_len == '0;
            r_state <= r_len == '0 ? ST_IDLE : ST_READ;
          end
        end
        ST_READ: begin
          if (!cpu_busy) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_byte  <= w_lane;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!cpu_busy) begin
            r_src   <= r_src + 12'd1;
            r_dst   <= r_dst + 7'd1;
            r_len   <= r_len - LEN_W'(1);
            r_state <= w_last ? ST_IDLE : ST_READ;
            if (w_last && !w_abort) r_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_abort) r_state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma: randomized and directed checks of vram_dma against a byte-level copy model
module tb_vram_dma;
  import dma_pkg::*;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        reg_sel = 0;
  logic [1:0]  reg_addr = 0;
  logic [31:0] reg_wdata = 0;
  logic        reg_wenable = 0;
  logic [31:0] reg_rdata;
  logic        cpu_busy = 0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wenable;
  logic [31:0] mem_rdata = 0;
  logic        dma_done;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  ram [4096];
  logic [14:0] obs [$];
  int          req_cnt = 0;
  bit          mon_en = 0;
  bit          rd_pend = 0;
  logic [31:0] rd_word = 0;
  bit          pat [512];
  always #5 clk = ~clk;
  vram_dma #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .reg_sel(reg_sel), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wenable(reg_wenable), .reg_rdata(reg_rdata),
    .cpu_busy(cpu_busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wenable(mem_wenable), .mem_rdata(mem_rdata),
    .dma_done(dma_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Bus monitor: checks ownership rules, records VRAM writes, models RAM read latency
  initial forever begin
    @(negedge clk);
    rd_pend = 0;
    if (mon_en) begin
      if (cpu_busy) chk("req_while_busy", 32'(mem_req), 0);
      if (!mem_req) chk("idle_bus_zero", 32'((|mem_addr) | (|mem_wdata) | (|mem_wenable)), 0);
      else begin
        req_cnt++;
        if (mem_wenable != 0) begin
          chk("wr_wen", 32'(mem_wenable), 1);
          chk("wr_base", mem_addr & ~32'h7f, VRAM_BASE);
          chk("wr_data_hi", mem_wdata & ~32'hff, 0);
          obs.push_back({mem_addr[6:0], mem_wdata[7:0]});
        end else begin
          chk("rd_addr_fmt", mem_addr & ~32'hffc, 0);
          rd_pend = 1;
          rd_word = {ram[{mem_addr[11:2], 2'd3}], ram[{mem_addr[11:2], 2'd2}],
                     ram[{mem_addr[11:2], 2'd1}], ram[{mem_addr[11:2], 2'd0}]};
        end
      end
    end
  end
  // Read data is valid only in the cycle after an issued read, noise otherwise
  initial forever begin
    @(posedge clk);
    #1;
    mem_rdata = rd_pend ? rd_word : $urandom;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_sel = 1; reg_wenable = 1; reg_addr = a; reg_wdata = d;
    step();
    reg_sel = 0; reg_wenable = 0;
  endtask
  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
    reg_addr = a;
    #1;
    chk(tag, reg_rdata, e);
  endtask
  // Cycle (relative to the start write) at which done is first visible
  function automatic int predict(input int n);
    int c = 1;
    for (int i = 0; i < n; i++) begin
      while (pat[c]) c++;
      c += 2;
      while (pat[c]) c++;
      c++;
    end
    return c;
  endfunction
  task automatic run_xfer(input logic [11:0] src, input logic [6:0] dst, input int len,
                          input bit inj, output int kd);
    logic [14:0] expq [$];
    int exp_t;
    int k;
    int lim;
    for (int i = 0; i < len; i++)
      expq.push_back({7'((int'(dst) + i) % 128), ram[(int'(src) + i) % 4096]});
    exp_t = predict(len);
    lim = exp_t + 20;
    wr(REG_SRC, 32'(src));
    wr(REG_DST, 32'(dst));
    wr(REG_LEN, 32'(len));
    obs.delete();
    wr(REG_CTRL, 32'h1);
    k = 1;
    cpu_busy = pat[1];
    while (!dma_done && k < lim) begin
      if (inj && k == 2) begin reg_sel = 1; reg_wenable = 1; reg_addr = REG_SRC; reg_wdata = 32'h200; end
      if (inj && k == 5) begin reg_sel = 1; reg_wenable = 1; reg_addr = REG_CTRL; reg_wdata = 32'h1; end
      step();
      reg_sel = 0; reg_wenable = 0;
      k++;
      cpu_busy = pat[k];
    end
    cpu_busy = 0;
    kd = k;
    chk("done_cycle", 32'(k), 32'(exp_t));
    chk("nwrites", 32'(obs.size()), 32'(len));
    for (int i = 0; i < len && i < obs.size(); i++) chk("wr_pair", 32'(obs[i]), 32'(expq[i]));
    chk_reg("src_after", REG_SRC, 32'((int'(src) + len) % 4096));
    chk_reg("dst_after", REG_DST, 32'((int'(dst) + len) % 128));
    chk_reg("ctrl_after", REG_CTRL, 32'h2);
    step();
  endtask
  initial begin
    int kd;
    int r;
    int n;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    for (int i = 0; i < 512; i++) pat[i] = 0;
    repeat (3) step();
    rst_n = 1;
    mon_en = 1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_done", 32'(dma_done), 0);
    chk_reg("rst_src", REG_SRC, 0);
    chk_reg("rst_dst", REG_DST, 0);
    chk_reg("rst_len", REG_LEN, 0);
    chk_reg("rst_ctrl", REG_CTRL, 0);
    step();
    run_xfer(12'h100, 7'd5, 4, 0, kd);
    chk("basic_t13", 32'(kd), 13);
    for (int i = 4; i <= 8; i++) pat[i] = 1;
    run_xfer(12'h100, 7'd5, 4, 0, kd);
    chk("busy_t18", 32'(kd), 18);
    for (int i = 0; i < 512; i++) pat[i] = 0;
    wr(REG_CTRL, 32'h2);
    chk("clear_done", 32'(dma_done), 0);
    wr(REG_LEN, 0);
    r = req_cnt;
    wr(REG_CTRL, 32'h1);
    chk("len0_done", 32'(dma_done), 1);
    repeat (4) step();
    chk("len0_noreq", 32'(req_cnt), 32'(r));
    run_xfer(12'hffe, 7'd126, 3, 0, kd);
    run_xfer(12'h300, 7'd40, 3, 1, kd);
    wr(REG_SRC, 32'h40);
    wr(REG_DST, 32'd10);
    wr(REG_LEN, 32'd6);
    obs.delete();
    wr(REG_CTRL, 32'h1);
    n = 0;
    while (obs.size() < 2 && n < 50) begin step(); n++; end
    chk("abort_reach", 32'(obs.size()), 2);
    wr(REG_CTRL, 32'h4);
    chk_reg("abort_ctrl", REG_CTRL, 32'h400);
    chk("abort_done", 32'(dma_done), 0);
    chk_reg("abort_src", REG_SRC, 32'h42);
    repeat (10) step();
    chk("abort_nowr", 32'(obs.size()), 2);
    wr(REG_SRC, 32'h80);
    wr(REG_DST, 32'd20);
    wr(REG_LEN, 32'd10);
    wr(REG_CTRL, 32'h1);
    repeat (5) step();
    rst_n = 0;
    step();
    rst_n = 1;
    obs.delete();
    chk("mrst_req", 32'(mem_req), 0);
    chk("mrst_done", 32'(dma_done), 0);
    chk_reg("mrst_src", REG_SRC, 0);
    chk_reg("mrst_len", REG_LEN, 0);
    chk_reg("mrst_ctrl", REG_CTRL, 0);
    repeat (10) step();
    chk("mrst_nowr", 32'(obs.size()), 0);
    for (int t = 0; t < 10; t++) begin
      for (int i = 1; i < 512; i++) pat[i] = ($urandom_range(0, 2) == 0);
      run_xfer(12'($urandom_range(0, 4095)), 7'($urandom_range(0, 127)),
               $urandom_range(1, 20), 0, kd);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
